// File: rtl/analogue_waveform_generator.sv
// Multi-channel phase-accumulator waveform source (DC/saw/square/triangle) with
// amplitude scaling, saturating offset and a valid/ready sample output.
module analogue_waveform_generator #(
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 12,
    parameter int PHASE_WIDTH = 32
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_cfg_wr,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] i_cfg_chan,
    input  logic [1:0]                                  i_cfg_addr,
    input  logic [PHASE_WIDTH-1:0]                      i_cfg_data,
    input  logic                                        i_sample_tick,
    input  logic                                        i_phase_sync,
    input  logic                                        i_overrun_clr,
    output logic [CHANNELS*DATA_WIDTH-1:0]              o_sample_data,
    output logic                                        o_sample_valid,
    input  logic                                        i_sample_ready,
    output logic                                        o_overrun
);

    localparam int CW = $clog2(CHANNELS > 1 ? CHANNELS : 2);
    localparam logic [DATA_WIDTH-1:0] M = '1;

    typedef enum logic [1:0] {
        MODE_DC     = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_TRI    = 2'd3
    } mode_t;

    logic r_s1_valid;
    logic r_valid;
    logic r_overrun;
    logic w_busy;
    logic w_accept;
    logic w_drop;

    assign w_busy   = r_s1_valid | r_valid;
    assign w_accept = i_sample_tick & ~w_busy;
    assign w_drop   = i_sample_tick & w_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (r_s1_valid) begin
                r_valid <= 1'b1;
            end else if (r_valid && i_sample_ready) begin
                r_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear must leave the flag set.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_sample_valid = r_valid;
    assign o_overrun      = r_overrun;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic                   r_en;
        mode_t                  r_mode;
        logic [PHASE_WIDTH-1:0] r_inc;
        logic [DATA_WIDTH-1:0]  r_amp;
        logic [DATA_WIDTH-1:0]  r_off;
        logic [PHASE_WIDTH-1:0] r_phase;

        logic                   r_s1_en;
        logic [DATA_WIDTH-1:0]  r_s1_scaled;
        logic [DATA_WIDTH-1:0]  r_s1_off;
        logic [DATA_WIDTH-1:0]  r_lane;

        logic                   w_sel;
        logic [PHASE_WIDTH-1:0] w_samp_phase;
        logic [DATA_WIDTH-1:0]  w_p;
        logic [DATA_WIDTH-1:0]  w_p2;
        logic [DATA_WIDTH-1:0]  w_raw;
        logic [DATA_WIDTH:0]    w_amp1;
        logic [2*DATA_WIDTH:0]  w_prod;
        logic [DATA_WIDTH-1:0]  w_scaled;
        logic [DATA_WIDTH:0]    w_sum;
        logic [DATA_WIDTH-1:0]  w_lane;

        assign w_sel = i_cfg_wr && (i_cfg_chan == CW'(c));

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_en   <= 1'b0;
                r_mode <= MODE_DC;
                r_inc  <= '0;
                r_amp  <= '0;
                r_off  <= '0;
            end else if (w_sel) begin
                case (i_cfg_addr)
                    2'd0: begin
                        r_en   <= i_cfg_data[2];
                        r_mode <= mode_t'(i_cfg_data[1:0]);
                    end
                    2'd1:    r_inc <= i_cfg_data;
                    2'd2:    r_amp <= i_cfg_data[DATA_WIDTH-1:0];
                    default: r_off <= i_cfg_data[DATA_WIDTH-1:0];
                endcase
            end
        end

        // A sync coinciding with an accepted tick samples phase 0 and restarts from inc.
        assign w_samp_phase = i_phase_sync ? '0 : r_phase;

        always_ff @(posedge i_clk) begin
            if (i_rst || !r_en) begin
                r_phase <= '0;
            end else if (w_accept) begin
                r_phase <= w_samp_phase + r_inc;
            end else if (i_phase_sync) begin
                r_phase <= '0;
            end
        end

        assign w_p  = w_samp_phase[PHASE_WIDTH-1 -: DATA_WIDTH];
        assign w_p2 = w_p << 1;

        always_comb begin
            w_raw = '0;
            case (r_mode)
                MODE_DC:     w_raw = M;
                MODE_SAW:    w_raw = w_p;
                MODE_SQUARE: w_raw = w_p[DATA_WIDTH-1] ? M : '0;
                default:     w_raw = w_p[DATA_WIDTH-1] ? ~w_p2 : w_p2;
            endcase
        end

        assign w_amp1   = {1'b0, r_amp} + (DATA_WIDTH+1)'(1);
        assign w_prod   = (2*DATA_WIDTH+1)'(w_raw) * (2*DATA_WIDTH+1)'(w_amp1);
        assign w_scaled = DATA_WIDTH'(w_prod >> DATA_WIDTH);

        // Stage 1 also captures en/offset so later config writes leave this sample alone.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_s1_en     <= 1'b0;
                r_s1_scaled <= '0;
                r_s1_off    <= '0;
            end else if (w_accept) begin
                r_s1_en     <= r_en;
                r_s1_scaled <= w_scaled;
                r_s1_off    <= r_off;
            end
        end

        assign w_sum  = {1'b0, r_s1_scaled} + {1'b0, r_s1_off};
        assign w_lane = !r_s1_en        ? '0 :
                        w_sum[DATA_WIDTH] ? M  : w_sum[DATA_WIDTH-1:0];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_lane <= '0;
            end else if (r_s1_valid) begin
                r_lane <= w_lane;
            end
        end

        assign o_sample_data[c*DATA_WIDTH +: DATA_WIDTH] = r_lane;
    end

endmodule

// File: tb/tb_analogue_waveform_generator.sv
// Directed bench for analogue_waveform_generator: saw, square, saturation,
// backpressure/overrun, sync/disable and mid-operation reset.
module tb_analogue_waveform_generator;

    localparam int CH = 2;
    localparam int DW = 12;
    localparam int PW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_wr;
    logic [0:0]        cfg_chan;
    logic [1:0]        cfg_addr;
    logic [PW-1:0]     cfg_data;
    logic              sample_tick;
    logic              phase_sync;
    logic              overrun_clr;
    logic [CH*DW-1:0]  sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;

    analogue_waveform_generator #(
        .CHANNELS   (CH),
        .DATA_WIDTH (DW),
        .PHASE_WIDTH(PW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cfg_wr      (cfg_wr),
        .i_cfg_chan    (cfg_chan),
        .i_cfg_addr    (cfg_addr),
        .i_cfg_data    (cfg_data),
        .i_sample_tick (sample_tick),
        .i_phase_sync  (phase_sync),
        .i_overrun_clr (overrun_clr),
        .o_sample_data (sample_data),
        .o_sample_valid(sample_valid),
        .i_sample_ready(sample_ready),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [0:0] ch, input logic [1:0] addr, input logic [PW-1:0] data);
        cfg_wr   = 1'b1;
        cfg_chan = ch;
        cfg_addr = addr;
        cfg_data = data;
        step(1);
        cfg_wr   = 1'b0;
    endtask

    // One tick with ready=1: valid must appear exactly two cycles later and drop after accept.
    task automatic sample(input string tag, input logic sync,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        sample_tick = 1'b1;
        phase_sync  = sync;
        step(1);
        sample_tick = 1'b0;
        phase_sync  = 1'b0;
        check({tag, "_t1_valid"}, 32'(sample_valid), 32'd0);
        step(1);
        check({tag, "_valid"}, 32'(sample_valid), 32'd1);
        check({tag, "_lane0"}, 32'(sample_data[DW-1:0]), 32'(e0));
        check({tag, "_lane1"}, 32'(sample_data[2*DW-1:DW]), 32'(e1));
        step(1);
        check({tag, "_drop"}, 32'(sample_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        cfg_wr       = 1'b0;
        cfg_chan     = '0;
        cfg_addr     = '0;
        cfg_data     = '0;
        sample_tick  = 1'b0;
        phase_sync   = 1'b0;
        overrun_clr  = 1'b0;
        sample_ready = 1'b1;
        step(2);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_data", 32'(sample_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        step(1);

        // ch0 saw, full amplitude: 0x000..0xF00 then wrap to 0x000
        cfg(1'b0, 2'd2, 16'h0FFF);
        cfg(1'b0, 2'd3, 16'h0000);
        cfg(1'b0, 2'd1, 16'h1000);
        cfg(1'b0, 2'd0, 16'h0005);
        for (int i = 0; i < 17; i++)
            sample("saw", 1'b0, 12'((i % 16) * 12'h100), 12'h000);

        // offset 0x800 on saw: sync restarts at phase 0, sums above 0xFFF saturate
        cfg(1'b0, 2'd3, 16'h0800);
        sample("sat_sync", 1'b1, 12'h800, 12'h000);
        for (int i = 1; i < 10; i++)
            sample("sat", 1'b0, (i * 'h100 + 'h800 > 'hFFF) ? 12'hFFF : 12'(i * 'h100 + 'h800), 12'h000);

        // ch0 disabled (lane must be 0 despite offset); ch1 square, amp 0x7FF, off 0x400
        cfg(1'b0, 2'd0, 16'h0000);
        cfg(1'b1, 2'd1, 16'h2000);
        cfg(1'b1, 2'd2, 16'h07FF);
        cfg(1'b1, 2'd3, 16'h0400);
        cfg(1'b1, 2'd0, 16'h0006);
        for (int i = 0; i < 16; i++)
            sample("square", 1'b0, 12'h000, ((i % 8) < 4) ? 12'h400 : 12'hBFF);

        // backpressure: ch1 saw amp 0xFFF off 0x400, phase wrapped to 0
        cfg(1'b1, 2'd2, 16'h0FFF);
        cfg(1'b1, 2'd0, 16'h0005);
        sample_ready = 1'b0;
        sample_tick  = 1'b1;
        step(1);
        sample_tick  = 1'b0;
        step(1);
        check("bp_valid", 32'(sample_valid), 32'd1);
        check("bp_lane1", 32'(sample_data[2*DW-1:DW]), 32'h400);
        check("bp_no_overrun", 32'(overrun), 32'd0);
        step(2);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(3);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_hold_valid", 32'(sample_valid), 32'd1);
        check("bp_hold_lane1", 32'(sample_data[2*DW-1:DW]), 32'h400);
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        step(1);
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        check("clr_vs_drop", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("clr_overrun", 32'(overrun), 32'd0);
        check("clr_hold_valid", 32'(sample_valid), 32'd1);
        sample_ready = 1'b1;
        step(1);
        check("bp_accept", 32'(sample_valid), 32'd0);
        step(1);
        check("bp_single", 32'(sample_valid), 32'd0);
        sample("bp_next", 1'b0, 12'h000, 12'h600);

        // sync and disable: ch0 saw inc 0x1000 from 0, ch1 saw inc 0x2000 at 0x4000
        cfg(1'b1, 2'd3, 16'h0000);
        cfg(1'b0, 2'd3, 16'h0000);
        cfg(1'b0, 2'd0, 16'h0005);
        sample("two_a", 1'b0, 12'h000, 12'h400);
        sample("two_b", 1'b0, 12'h100, 12'h600);
        sample("sync", 1'b1, 12'h000, 12'h000);
        sample("post_sync", 1'b0, 12'h100, 12'h200);
        cfg(1'b1, 2'd0, 16'h0000);
        sample("ch1_off", 1'b0, 12'h200, 12'h000);

        // reset while a sample is held with ready low
        sample_ready = 1'b0;
        sample_tick  = 1'b1;
        step(1);
        sample_tick  = 1'b0;
        step(1);
        check("pre_rst_valid", 32'(sample_valid), 32'd1);
        check("pre_rst_lane0", 32'(sample_data[DW-1:0]), 32'h300);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_data", 32'(sample_data), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        sample_ready = 1'b1;
        sample("post_rst", 1'b0, 12'h000, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
